// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Writeback stage behind the load/store unit. Selects the
//                result source and buffers results in a 2-entry skid
//                buffer (head = oldest, skid = younger). Drives the
//                register-file write port under a ready/valid handshake.
//                Counts completed register-file writes.
//                Compile-time option WB_BYPASS_EN adds a forwarding lookup
//                over the buffered entries. Without it, byp_hit and
//                byp_data are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_load,
    input  logic [DATA_W-1:0] in_imm,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    input  logic [REG_AW-1:0] byp_raddr,
    output logic              byp_hit,
    output logic [DATA_W-1:0] byp_data,
    output logic [31:0]       retired_cnt
);

    // Buffer occupancy states
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [1:0] c_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_IMM  = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic              r_head_wr;
    logic [REG_AW-1:0] r_head_waddr;
    logic [DATA_W-1:0] r_head_wdata;
    logic              r_skid_wr;
    logic [REG_AW-1:0] r_skid_waddr;
    logic [DATA_W-1:0] r_skid_wdata;
    logic [31:0]       r_retired_cnt;

    logic              w_head_valid;
    logic              w_accept;
    logic              w_retire;
    logic              w_in_wr;
    logic [DATA_W-1:0] w_in_wdata;

    // Source mux and write-enable for the incoming result
    always_comb begin
        w_in_wdata = '0;
        case (in_sel)
            c_SEL_ALU:  w_in_wdata = in_alu;
            c_SEL_LOAD: w_in_wdata = in_load;
            c_SEL_IMM:  w_in_wdata = in_imm;
            default:    w_in_wdata = '0;
        endcase
        w_in_wr = (in_sel != 2'b11) && (in_rd != '0);
    end

    // Non-writing entries retire without waiting for the register file
    assign w_accept = in_valid && in_ready;
    assign w_retire = w_head_valid && (!r_head_wr || rf_ready);

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_next = S_ONE;
            S_ONE: begin
                if (w_accept && !w_retire)      w_state_next = S_TWO;
                else if (!w_accept && w_retire) w_state_next = S_EMPTY;
            end
            S_TWO:   if (w_retire) w_state_next = S_ONE;
            default: w_state_next = S_EMPTY;
        endcase
    end

    // State-derived outputs; in_ready never looks at rf_ready
    always_comb begin
        w_head_valid = (r_state != S_EMPTY);
        in_ready     = (r_state != S_TWO) && !rst;
    end

    // Head/skid payload movement: simultaneous accept+retire in ONE
    // replaces the head, and retiring from TWO promotes the skid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_wr    <= 1'b0;
            r_head_waddr <= '0;
            r_head_wdata <= '0;
            r_skid_wr    <= 1'b0;
            r_skid_waddr <= '0;
            r_skid_wdata <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_head_wr    <= w_in_wr;
                        r_head_waddr <= in_rd;
                        r_head_wdata <= w_in_wdata;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_retire) begin
                        r_head_wr    <= w_in_wr;
                        r_head_waddr <= in_rd;
                        r_head_wdata <= w_in_wdata;
                    end else if (w_accept) begin
                        r_skid_wr    <= w_in_wr;
                        r_skid_waddr <= in_rd;
                        r_skid_wdata <= w_in_wdata;
                    end
                end
                S_TWO: begin
                    if (w_retire) begin
                        r_head_wr    <= r_skid_wr;
                        r_head_waddr <= r_skid_waddr;
                        r_head_wdata <= r_skid_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count retirements that actually wrote the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
        end else if (w_retire && r_head_wr) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    // Register-file port; address/data forced to 0 when not writing
    always_comb begin
        rf_we    = w_head_valid && r_head_wr;
        rf_waddr = rf_we ? r_head_waddr : '0;
        rf_wdata = rf_we ? r_head_wdata : '0;
    end

    assign retired_cnt = r_retired_cnt;

`ifdef WB_BYPASS_EN
    logic w_skid_valid;
    logic w_head_hit;
    logic w_skid_hit;

    // Forwarding lookup; the younger skid entry takes priority
    always_comb begin
        w_skid_valid = (r_state == S_TWO);
        w_head_hit   = w_head_valid && r_head_wr && (r_head_waddr == byp_raddr) && (byp_raddr != '0);
        w_skid_hit   = w_skid_valid && r_skid_wr && (r_skid_waddr == byp_raddr) && (byp_raddr != '0);
        byp_hit      = w_head_hit || w_skid_hit;
        byp_data     = w_skid_hit ? r_skid_wdata : (w_head_hit ? r_head_wdata : '0);
    end
`else
    logic w_byp_unused;
    assign w_byp_unused = ^byp_raddr;
    assign byp_hit      = 1'b0;
    assign byp_data     = '0;
`endif

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback stage directly downstream of the load/store unit. Accepts one completed instruction result per cycle (ALU result, load data, or load-immediate value) with its destination register index, buffers it in a 2-entry skid buffer, and drives the register-file write port under a ready/valid handshake. Optionally exposes a lookup port so decode can forward pending writeback values.

## Interface
- DATA_W, 32, width of data paths
- REG_AW, 5, register index width (32 registers; index 0 is the hard-wired $0)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  stage can accept a result this cycle
- in_sel  in  2  source: 00 ALU, 01 load, 10 load-immediate, 11 no writeback (store/nop)
- in_rd  in  REG_AW  destination register index
- in_alu  in  DATA_W  ALU result
- in_load  in  DATA_W  load data from the load/store unit
- in_imm  in  DATA_W  immediate for load-immediate
- rf_we  out  1  register-file write request
- rf_waddr  out  REG_AW  write index
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts the write this cycle
- byp_raddr  in  REG_AW  forwarding lookup index
- byp_hit  out  1  a buffered entry will write byp_raddr
- byp_data  out  DATA_W  value to forward on hit
- retired_cnt  out  32  count of completed register-file writes

## Operation
- Entry captured on posedge when in_valid && in_ready. Captured: waddr = in_rd, wdata = mux(in_sel), wr = (in_sel != 11) && (in_rd != 0).
- wdata mux: 00 → in_alu; 01 → in_load; 10 → 32'h0 | in_imm (immediate unchanged); 11 → 0.
- Storage: head (oldest) and skid (younger). Occupancy FSM: EMPTY → ONE on accept; ONE → TWO on accept without retire; ONE → EMPTY on retire without accept; ONE stays ONE on simultaneous accept+retire (new entry becomes head); TWO → ONE on retire (skid moves to head).
- in_ready = (state != TWO); combinational from state only, never from rf_ready.
- rf_we = head valid && head.wr; rf_waddr/rf_wdata from head; with rf_we low, rf_waddr and rf_wdata are 0.
- Retire: head valid && (!head.wr || rf_ready). Non-writing entries retire in the cycle after capture without waiting on rf_ready.
- rf_we, rf_waddr, rf_wdata hold stable while rf_ready is low.
- retired_cnt increments by 1 for each retire with head.wr = 1; wraps 32'hFFFFFFFF → 0.
- Order preserved: writes reach the register file in acceptance order.

## Timing
- Latency: result accepted at edge N appears on rf_we/rf_wdata after edge N (cycle N+1) when the buffer was empty.
- Throughput: 1 per cycle while rf_ready held high.
- Reset: state EMPTY, both entries invalid, rf_we 0, rf_waddr 0, rf_wdata 0, in_ready 1 after reset edge, byp_hit 0, byp_data 0, retired_cnt 0. rst overrides any accept or retire on that edge; in-flight entries are discarded.
- in_ready is 0 while rst is high.
- rf_ready with rf_we low is ignored.

## Configuration
- WB_BYPASS_EN defined: byp_hit/byp_data combinational from both valid entries: hit when entry.wr && entry.waddr == byp_raddr; skid (younger) wins over head; byp_raddr = 0 never hits.
- WB_BYPASS_EN undefined: byp_hit and byp_data tied to 0; no compare logic.

## Test plan
- Reset then accept in_sel=00, in_rd=3, in_alu=32'hDEADBEEF, rf_ready=1 → next cycle rf_we=1, rf_waddr=3, rf_wdata=32'hDEADBEEF; retired_cnt=1.
- Back-pressure: rf_ready=0, accept rd=1 load 32'h11 then rd=2 li imm 32'h22 → in_ready=0 after second accept; third in_valid not captured; raise rf_ready → writes 32'h11 to r1 then 32'h22 to r2 on consecutive cycles, in_ready returns to 1.
- Accept in_sel=11 rd=5, and in_sel=00 rd=0 → rf_we never asserts, both retire with rf_ready=0, retired_cnt unchanged.
- With WB_BYPASS_EN, rf_ready=0, head rd=4 data 32'hA, skid rd=4 data 32'hB, byp_raddr=4 → byp_hit=1, byp_data=32'hB; byp_raddr=0 → byp_hit=0.
- Assert rst while state TWO → next cycle rf_we=0, in_ready=1, retired_cnt=0; no stale write after release.
- Preload retired_cnt near wrap (drive 2 writes after forcing 32'hFFFFFFFF) → counter reads 0 then 1.
